// File: rtl/pipeline_ctrl.sv
// Pipeline control for a five-stage MIPS-style core: per-stage stall
// generation, exception/ERET flush with redirect target, and the multi-cycle
// divider sequencer that holds EXE while a DIV/DIVU is in progress.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_exe,
  input  logic        exe_div_start,
  input  logic        stallreq_mem,
  input  logic        mem_exc_valid,
  input  logic        mem_exc_is_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        div_busy,
  output logic        div_done
);

  // Stall patterns: bit k set means stage boundary k holds its contents.
  // Every pattern is a run of ones from bit 0, so the first clear bit above
  // the run is where a bubble enters the pipeline.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EXE  = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // General exception entry point (BEV = 1).
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Divider sequencer states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] DIV_LAST = 5'd31;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [4:0] div_cnt;
  logic [4:0] div_cnt_next;
  logic       div_stall;
  logic       exe_hold;

  // Flush is a same-cycle reaction to an exception or ERET reaching MEM;
  // it is masked while reset is held so all outputs read zero.
  always_comb begin
    flush    = resetn & mem_exc_valid;
    flush_pc = '0;
    if (flush) begin
      flush_pc = mem_exc_is_eret ? cp0_epc : EXC_VECTOR;
    end
  end

  // The divider holds EXE from the cycle a divide shows up until it finishes.
  always_comb begin
    div_stall = (state == S_BUSY) || ((state == S_IDLE) && exe_div_start);
    exe_hold  = stallreq_exe || div_stall;
  end

  // Priority stall encoder: the deepest requesting stage wins; a flush
  // releases everything so the redirect can take effect.
  always_comb begin
    stall = STALL_NONE;
    if (!resetn || flush) begin
      stall = STALL_NONE;
    end else if (stallreq_mem) begin
      stall = STALL_MEM;
    end else if (exe_hold) begin
      stall = STALL_EXE;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end else if (stallreq_if) begin
      stall = STALL_IF;
    end
  end

  // Divider next-state: 32 counted BUSY cycles, then DONE until EXE/MEM
  // accepts the result. DONE waits on stall[3] so a held divide is not
  // restarted while the result is still sitting in EXE.
  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    if (flush) begin
      state_next   = S_IDLE;
      div_cnt_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (exe_div_start) begin
            state_next   = S_BUSY;
            div_cnt_next = '0;
          end
        end
        S_BUSY: begin
          // A MEM stall freezes the count; EXE keeps its operands meanwhile.
          if (!stallreq_mem) begin
            if (div_cnt == DIV_LAST) begin
              state_next = S_DONE;
            end else begin
              div_cnt_next = div_cnt + 5'd1;
            end
          end
        end
        S_DONE: begin
          if (!stall[3]) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next   = S_IDLE;
          div_cnt_next = '0;
        end
      endcase
    end
  end

  // Divider state register; asynchronous reset abandons any divide in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      div_cnt <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    div_busy = (state == S_BUSY);
    div_done = (state == S_DONE);
  end

  // Stall must always be a contiguous run of ones starting at bit 0.
  a_stall_contiguous : assert property (
    @(posedge clk) disable iff (!resetn) ((stall + 6'd1) & stall) == 6'd0
  );

  // A flush never coexists with any stall.
  a_flush_no_stall : assert property (
    @(posedge clk) disable iff (!resetn) flush |-> (stall == STALL_NONE)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a table of combinational vectors,
// hand-written divider/flush/reset sequences, and a randomized run compared
// against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_exe;
  logic        exe_div_start;
  logic        stallreq_mem;
  logic        mem_exc_valid;
  logic        mem_exc_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        div_busy;
  logic        div_done;

  int errors = 0;
  int checks = 0;

  pipeline_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_exe   (stallreq_exe),
    .exe_div_start  (exe_div_start),
    .stallreq_mem   (stallreq_mem),
    .mem_exc_valid  (mem_exc_valid),
    .mem_exc_is_eret(mem_exc_is_eret),
    .cp0_epc        (cp0_epc),
    .stall          (stall),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .div_busy       (div_busy),
    .div_done       (div_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s_if;
    logic        s_id;
    logic        s_exe;
    logic        s_mem;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if     = 1'b0;
    stallreq_id     = 1'b0;
    stallreq_exe    = 1'b0;
    exe_div_start   = 1'b0;
    stallreq_mem    = 1'b0;
    mem_exc_valid   = 1'b0;
    mem_exc_is_eret = 1'b0;
    cp0_epc         = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  // Behavioural model. Divider progress p: -1 idle, 0..31 busy cycles
  // completed, 32 result ready. Stall is a run of ones of length "depth".
  int m_p;

  function automatic int depth_of(input logic rn, input logic exc, input logic mem,
                                  input logic exe, input logic id, input logic fi,
                                  input logic start, input int p);
    logic hold;
    hold = exe || (p >= 0 && p < 32) || (p < 0 && start);
    if (!rn || exc) return 0;
    if (mem)  return 5;
    if (hold) return 4;
    if (id)   return 3;
    if (fi)   return 2;
    return 0;
  endfunction

  function automatic logic [5:0] run_of_ones(input int d);
    int unsigned v;
    v = (32'd1 << d) - 32'd1;
    return v[5:0];
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d;
    int next_p;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;

    clear_inputs();
    resetn = 1'b0;
    #2;

    // Reset state, with active requests that must be masked.
    stallreq_mem  = 1'b1;
    mem_exc_valid = 1'b1;
    exe_div_start = 1'b1;
    #1;
    check("rst_stall", {26'd0, stall}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_pc",    flush_pc, 32'd0);
    check("rst_busy",  {31'd0, div_busy}, 32'd0);
    check("rst_done",  {31'd0, div_done}, 32'd0);
    do_reset();

    // Combinational vector table, divider left idle.
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000000,1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000011,1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        6'b011111,1'b0,32'h0};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        6'b001111,1'b0,32'h0};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        6'b000111,1'b0,32'h0};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        6'b001111,1'b0,32'h0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        6'b011111,1'b0,32'h0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,32'hBFC00100, 6'b000000,1'b1,32'hBFC00380};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,32'h12345678, 6'b000000,1'b1,32'h12345678};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF, 6'b000011,1'b0,32'h0};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,32'h0,        6'b000000,1'b1,32'hBFC00380};

    for (int i = 0; i < 12; i++) begin
      stallreq_if     = vecs[i].s_if;
      stallreq_id     = vecs[i].s_id;
      stallreq_exe    = vecs[i].s_exe;
      stallreq_mem    = vecs[i].s_mem;
      mem_exc_valid   = vecs[i].exc;
      mem_exc_is_eret = vecs[i].eret;
      cp0_epc         = vecs[i].epc;
      #1;
      check($sformatf("vec%0d_stall", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("vec%0d_pc", i),    flush_pc, vecs[i].exp_pc);
      tick();
    end

    // Full divide: stall 001111 for cycles 0..32, done at 33, then idle.
    do_reset();
    exe_div_start = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      #1;
      check($sformatf("div_c%0d_stall", c), {26'd0, stall}, 32'h0000000F);
      check($sformatf("div_c%0d_busy", c), {31'd0, div_busy}, (c >= 1) ? 32'd1 : 32'd0);
      check($sformatf("div_c%0d_done", c), {31'd0, div_done}, 32'd0);
      tick();
    end
    #1;
    check("div_c33_done",  {31'd0, div_done}, 32'd1);
    check("div_c33_stall", {26'd0, stall}, 32'd0);
    tick();
    exe_div_start = 1'b0;
    #1;
    check("div_c34_done",  {31'd0, div_done}, 32'd0);
    check("div_c34_busy",  {31'd0, div_busy}, 32'd0);
    check("div_c34_stall", {26'd0, stall}, 32'd0);

    // DONE held by a MEM stall; no new BUSY entry while held.
    do_reset();
    exe_div_start = 1'b1;
    for (int c = 0; c <= 32; c++) tick();
    stallreq_mem = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d_done", c),  {31'd0, div_done}, 32'd1);
      check($sformatf("hold%0d_busy", c),  {31'd0, div_busy}, 32'd0);
      check($sformatf("hold%0d_stall", c), {26'd0, stall}, 32'h0000001F);
      tick();
    end
    stallreq_mem = 1'b0;
    #1;
    check("hold_rel_done",  {31'd0, div_done}, 32'd1);
    check("hold_rel_stall", {26'd0, stall}, 32'd0);
    tick();
    exe_div_start = 1'b0;
    #1;
    check("hold_idle_done", {31'd0, div_done}, 32'd0);
    check("hold_idle_busy", {31'd0, div_busy}, 32'd0);

    // MEM stall in BUSY freezes the count: 4 frozen cycles delay done by 4.
    do_reset();
    exe_div_start = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    stallreq_mem = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    stallreq_mem = 1'b0;
    for (int c = 0; c < 22; c++) tick();
    #1;
    check("memfrz_c36_busy", {31'd0, div_busy}, 32'd1);
    tick();
    #1;
    check("memfrz_c37_done", {31'd0, div_done}, 32'd1);

    // ERET at div_cnt = 10 aborts the divide.
    do_reset();
    exe_div_start = 1'b1;
    for (int c = 0; c < 11; c++) tick();
    mem_exc_valid   = 1'b1;
    mem_exc_is_eret = 1'b1;
    cp0_epc         = 32'hBFC00100;
    #1;
    check("eret_flush", {31'd0, flush}, 32'd1);
    check("eret_pc",    flush_pc, 32'hBFC00100);
    check("eret_stall", {26'd0, stall}, 32'd0);
    check("eret_busy_before", {31'd0, div_busy}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("eret_busy_after", {31'd0, div_busy}, 32'd0);
    check("eret_done_after", {31'd0, div_done}, 32'd0);

    // Flush beats a simultaneous divide start in IDLE.
    exe_div_start = 1'b1;
    mem_exc_valid = 1'b1;
    tick();
    exe_div_start = 1'b0;
    mem_exc_valid = 1'b0;
    #1;
    check("flush_vs_start_busy", {31'd0, div_busy}, 32'd0);

    // Asynchronous reset mid-BUSY, then a fresh divide from IDLE.
    do_reset();
    exe_div_start = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    #1;
    check("areset_pre_busy", {31'd0, div_busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("areset_busy",  {31'd0, div_busy}, 32'd0);
    check("areset_stall", {26'd0, stall}, 32'd0);
    tick();
    resetn = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      #1;
      check($sformatf("rerun_c%0d_done", c), {31'd0, div_done}, 32'd0);
      tick();
    end
    #1;
    check("rerun_c33_done", {31'd0, div_done}, 32'd1);

    // Randomized run against the model.
    do_reset();
    m_p = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      resetn          = ($urandom_range(0, 299) != 0);
      stallreq_if     = ($urandom_range(0, 3) == 0);
      stallreq_id     = ($urandom_range(0, 4) == 0);
      stallreq_exe    = ($urandom_range(0, 9) == 0);
      exe_div_start   = ($urandom_range(0, 7) != 0);
      stallreq_mem    = ($urandom_range(0, 4) == 0);
      mem_exc_valid   = ($urandom_range(0, 59) == 0);
      mem_exc_is_eret = $urandom_range(0, 1) == 1;
      cp0_epc         = $urandom;
      #1;
      if (!resetn) m_p = -1;
      d = depth_of(resetn, mem_exc_valid, stallreq_mem, stallreq_exe,
                   stallreq_id, stallreq_if, exe_div_start, m_p);
      e_stall = run_of_ones(d);
      e_flush = resetn && mem_exc_valid;
      e_pc    = !e_flush ? 32'h0 : (mem_exc_is_eret ? cp0_epc : 32'hBFC00380);
      check("rnd_stall", {26'd0, stall}, {26'd0, e_stall});
      check("rnd_flush", {31'd0, flush}, {31'd0, e_flush});
      check("rnd_pc",    flush_pc, e_pc);
      check("rnd_busy",  {31'd0, div_busy}, (m_p >= 0 && m_p < 32) ? 32'd1 : 32'd0);
      check("rnd_done",  {31'd0, div_done}, (m_p == 32) ? 32'd1 : 32'd0);
      next_p = m_p;
      if (!resetn || e_flush)  next_p = -1;
      else if (m_p < 0)        next_p = exe_div_start ? 0 : -1;
      else if (m_p < 32)       next_p = stallreq_mem ? m_p : m_p + 1;
      else if (d < 4)          next_p = -1;
      tick();
      m_p = next_p;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
